regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port register file for the core's decode/writeback path, replacing the fixed 2-read/1-write register file. It provides NUM_RD_P registered read ports with write-first bypass and an optional hard-wired zero register. It also holds a pending-write scoreboard, so decode can see which source registers still await writeback. It sits between decode (reads, reservations) and writeback (writes).

## Interface
- DATA_WIDTH_P, 32, entry width
- ADDR_WIDTH_P, 5, address width
- DEPTH_P, 32, number of entries; must satisfy DEPTH_P <= 2**ADDR_WIDTH_P
- NUM_RD_P, 2, number of read ports (1..4)
- ZERO_REG_P, 1, when 1 entry 0 always reads 0, ignores writes and reservations
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_rd_en  in  NUM_RD_P  per-port read enable
- i_rd_addr  in  NUM_RD_P*ADDR_WIDTH_P  packed read addresses, port p at [p*ADDR_WIDTH_P +: ADDR_WIDTH_P]
- o_rd_data  out  NUM_RD_P*DATA_WIDTH_P  packed read data, same packing
- o_rd_pending  out  NUM_RD_P  per-port flag: the read register was pending at read time
- i_wr_en  in  1  write enable
- i_wr_addr  in  ADDR_WIDTH_P  write address
- i_wr_data  in  DATA_WIDTH_P  write data
- i_rsv_en  in  1  reserve (mark pending) enable
- i_rsv_addr  in  ADDR_WIDTH_P  reserved address
- o_pending_count  out  ADDR_WIDTH_P+1  number of pending entries
- o_err  out  1  sticky: out-of-range write or reservation seen

## Operation
- Reset: all DEPTH_P entries (including the last) cleared to 0. All pending bits cleared. o_rd_data, o_rd_pending, o_pending_count and o_err all 0.
- Read, port p with i_rd_en[p]=1:
  - Data is the entry at i_rd_addr[p].
  - Bypass: if i_wr_en=1 and i_wr_addr equals the read address (and the write is legal), the port returns i_wr_data (write-first).
  - Address 0 with ZERO_REG_P=1 returns 0.
  - Address >= DEPTH_P returns 0 and does not set o_err.
- i_rd_en[p]=0: port p holds its previous data and pending flag.
- Reads never stall on writes. All ports are independent, and any ports may share an address.
- Write: a legal write updates the entry and clears its pending bit. It is dropped when the address is >= DEPTH_P (sets o_err) or when it is address 0 with ZERO_REG_P=1 (silent).
- Reserve: a legal i_rsv_en sets pending[i_rsv_addr]. Out-of-range reservations are dropped and set o_err. Address 0 with ZERO_REG_P=1 is dropped silently.
- Write and reserve to the same address in the same cycle: the entry is written and the pending bit ends set (reservation wins).
- o_rd_pending[p] = pending[addr] AND NOT (same-cycle legal write hit). A same-cycle reservation is excluded, so an instruction reading its own destination sees the old value as valid.
- o_pending_count is the population count of the pending bits after the update. It is maintained incrementally:
  - +1 when a reservation sets a clear bit.
  - -1 when a write clears a set bit without a same-cycle reservation to that address.
  - Otherwise unchanged. It never wraps; its maximum is DEPTH_P.
- o_err is cleared only by reset.

## Timing
- All outputs are registered. Read latency is 1 cycle: address at edge N gives data and pending flag after edge N+1.
- A write at edge N is visible to reads issued at edge N (via bypass) and at every later edge.
- A reservation at edge N is reflected in o_rd_pending for reads issued at N+1 or later, and in o_pending_count after edge N+1.
- Reset asserted mid-operation overrides all same-cycle reads, writes and reservations. Outputs are 0 after that edge.

## Structure
- Shared package rf_pkg: default width/depth constants, the maximum NUM_RD_P, and the packed-slice index helpers.
- Sub-module rf_scoreboard: pending bit vector, pending-count counter and o_err. Inputs are the legal-write/legal-reserve strobes and addresses. It exposes pending bits to the read path.
- The top level holds the storage array, the zero-register and range qualification, the bypass muxes and the output registers.

## Test plan
- Reset then read all 32 addresses on both ports: every o_rd_data = 0, o_rd_pending = 0, o_pending_count = 0.
- Write 0xDEADBEEF to x5 while port 0 reads x5 in the same cycle: port 0 returns 0xDEADBEEF next cycle. Port 1 reading x5 one cycle later also returns 0xDEADBEEF.
- Write 0x1234 to x0 with ZERO_REG_P=1, then read x0: returns 0, and o_err stays 0.
- Reserve x7 then read x7: o_rd_pending=1 and count=1. Write x7 = 0x55 while reading x7: data 0x55, pending 0, count 0.
- Same-cycle reserve and write to x9: entry holds the written value, pending bit set, count=1. A read of x9 in that cycle reports pending 0.
- With DEPTH_P=24, write to address 30: write dropped, o_err=1 and held until reset.

Source files
------------

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
//   Shared definitions for the multi-port register file slice.
//   - Default entry width, address width and depth.
//   - Upper bound on the number of read ports.
//   - Helper that locates one port's slice inside a packed multi-port bus.
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DEPTH      = 32;
    localparam int RF_MAX_RD_P   = 4;

    // Low bit index of port `port` in a bus packed as {port[n-1], ..., port[0]}.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
//   Bundle of the decode/writeback signals of the register file.
//   master : decode + writeback side (drives reads, writes, reservations)
//   slave  : register file side (returns read data, pending flags, status)
//
//   i_rd_en         per-port read enable
//   i_rd_addr       packed read addresses, port p at [p*ADDR_WIDTH_P +: ADDR_WIDTH_P]
//   o_rd_data       packed registered read data, same packing
//   o_rd_pending    per-port flag: source register awaited writeback at read time
//   i_wr_en/addr/data  writeback port
//   i_rsv_en/addr   destination reservation from decode
//   o_pending_count number of entries awaiting writeback
//   o_err           sticky out-of-range write/reservation flag
// -----------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int DATA_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P = 5,
    parameter int NUM_RD_P     = 2
);

    logic [NUM_RD_P-1:0]              i_rd_en;
    logic [NUM_RD_P*ADDR_WIDTH_P-1:0] i_rd_addr;
    logic [NUM_RD_P*DATA_WIDTH_P-1:0] o_rd_data;
    logic [NUM_RD_P-1:0]              o_rd_pending;
    logic                             i_wr_en;
    logic [ADDR_WIDTH_P-1:0]          i_wr_addr;
    logic [DATA_WIDTH_P-1:0]          i_wr_data;
    logic                             i_rsv_en;
    logic [ADDR_WIDTH_P-1:0]          i_rsv_addr;
    logic [ADDR_WIDTH_P:0]            o_pending_count;
    logic                             o_err;

    modport master (
        output i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_rsv_en, i_rsv_addr,
        input  o_rd_data, o_rd_pending, o_pending_count, o_err
    );

    modport slave (
        input  i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_rsv_en, i_rsv_addr,
        output o_rd_data, o_rd_pending, o_pending_count, o_err
    );

endinterface

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
//   Pending-write tracking for the register file.
//   clk, reset     clock, synchronous active-high reset
//   wr_legal       qualified write strobe (in range, not the zero register)
//   wr_addr        write address
//   rsv_legal      qualified reservation strobe
//   rsv_addr       reservation address
//   oor_seen       an out-of-range write or reservation occurred this cycle
//   pending        current pending bits, one per entry (to the read path)
//   pending_count  registered population count of the pending bits
//   err            sticky out-of-range flag
// -----------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH_P = RF_ADDR_WIDTH,
    parameter int DEPTH_P      = RF_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_legal,
    input  logic [ADDR_WIDTH_P-1:0] wr_addr,
    input  logic                    rsv_legal,
    input  logic [ADDR_WIDTH_P-1:0] rsv_addr,
    input  logic                    oor_seen,
    output logic [DEPTH_P-1:0]      pending,
    output logic [ADDR_WIDTH_P:0]   pending_count,
    output logic                    err
);

    logic [DEPTH_P-1:0]    pending_q;
    logic [DEPTH_P-1:0]    wr_hot;
    logic [DEPTH_P-1:0]    rsv_hot;
    logic [DEPTH_P-1:0]    pending_next;
    logic [ADDR_WIDTH_P:0] count_q;
    logic                  cnt_inc;
    logic                  cnt_dec;
    logic                  err_q;

    // One-hot decode of the qualified strobes; callers guarantee that a
    // legal strobe never carries an address outside the array.
    always_comb begin
        wr_hot  = '0;
        rsv_hot = '0;
        for (int i = 0; i < DEPTH_P; i++) begin
            wr_hot[i]  = wr_legal  && (wr_addr  == ADDR_WIDTH_P'(i));
            rsv_hot[i] = rsv_legal && (rsv_addr == ADDR_WIDTH_P'(i));
        end
    end

    // Reservation is applied after the write clear, so it wins on a
    // same-address collision.
    assign pending_next = (pending_q & ~wr_hot) | rsv_hot;

    // Incremental count: a reservation only counts when it sets a clear bit,
    // a write only counts when it clears a set bit that is not re-reserved.
    // Both can fire together on different entries and cancel out.
    assign cnt_inc = |(rsv_hot & ~pending_q);
    assign cnt_dec = |(wr_hot & pending_q & ~rsv_hot);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_next;
            count_q   <= count_q + {{ADDR_WIDTH_P{1'b0}}, cnt_inc}
                                 - {{ADDR_WIDTH_P{1'b0}}, cnt_dec};
            err_q     <= err_q | oor_seen;
        end
    end

    assign pending       = pending_q;
    assign pending_count = count_q;
    assign err           = err_q;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised register file with NUM_RD_P registered read ports,
//   write-first bypass, optional hard-wired zero register and a pending-write
//   scoreboard for decode.
//   clk    clock
//   reset  synchronous, active-high; clears storage, scoreboard and outputs
//   bus    regfile_mp_if.slave: read ports, write port, reservation port,
//          pending flags/count and sticky error
//
//   Read latency is one cycle. A read of an address >= DEPTH_P, or of
//   entry 0 when ZERO_REG_P=1, returns 0 and is never pending. A port whose
//   enable is low holds its previous data and pending flag.
// -----------------------------------------------------------------------------
module regfile_mp
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH_P = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH_P = RF_ADDR_WIDTH,
    parameter int DEPTH_P      = RF_DEPTH,
    parameter int NUM_RD_P     = 2,
    parameter int ZERO_REG_P   = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);

    localparam logic [ADDR_WIDTH_P:0] DEPTH_L = (ADDR_WIDTH_P + 1)'(DEPTH_P);

    if (NUM_RD_P < 1 || NUM_RD_P > RF_MAX_RD_P) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD_P out of range");
    end
    if (DEPTH_P < 1 || DEPTH_P > (2 ** ADDR_WIDTH_P)) begin : g_bad_depth
        $error("regfile_mp: DEPTH_P does not fit ADDR_WIDTH_P");
    end

    function automatic logic addr_in_range(input logic [ADDR_WIDTH_P-1:0] addr);
        return {1'b0, addr} < DEPTH_L;
    endfunction

    function automatic logic addr_is_zero_reg(input logic [ADDR_WIDTH_P-1:0] addr);
        return (ZERO_REG_P != 0) && (addr == '0);
    endfunction

    // ---------------------------------------------------------------------
    // Write / reservation qualification
    // ---------------------------------------------------------------------
    logic wr_legal;
    logic wr_oor;
    logic rsv_legal;
    logic rsv_oor;

    assign wr_oor    = bus.i_wr_en  && !addr_in_range(bus.i_wr_addr);
    assign rsv_oor   = bus.i_rsv_en && !addr_in_range(bus.i_rsv_addr);
    assign wr_legal  = bus.i_wr_en  && addr_in_range(bus.i_wr_addr)
                                    && !addr_is_zero_reg(bus.i_wr_addr);
    assign rsv_legal = bus.i_rsv_en && addr_in_range(bus.i_rsv_addr)
                                    && !addr_is_zero_reg(bus.i_rsv_addr);

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    logic [DATA_WIDTH_P-1:0] mem [DEPTH_P];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_P; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_legal) begin
            mem[bus.i_wr_addr] <= bus.i_wr_data;
        end
    end

    // ---------------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------------
    logic [DEPTH_P-1:0]    pending;
    logic [ADDR_WIDTH_P:0] pending_count;
    logic                  err;

    rf_scoreboard #(
        .ADDR_WIDTH_P (ADDR_WIDTH_P),
        .DEPTH_P      (DEPTH_P)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .wr_legal      (wr_legal),
        .wr_addr       (bus.i_wr_addr),
        .rsv_legal     (rsv_legal),
        .rsv_addr      (bus.i_rsv_addr),
        .oor_seen      (wr_oor | rsv_oor),
        .pending       (pending),
        .pending_count (pending_count),
        .err           (err)
    );

    assign bus.o_pending_count = pending_count;
    assign bus.o_err           = err;

    // ---------------------------------------------------------------------
    // Read ports: qualification, bypass mux, output registers
    // ---------------------------------------------------------------------
    for (genvar p = 0; p < NUM_RD_P; p++) begin : g_rd
        logic [ADDR_WIDTH_P-1:0] addr;
        logic                    valid_addr;
        logic                    wr_hit;
        logic [DATA_WIDTH_P-1:0] data_d;
        logic                    pend_d;
        logic [DATA_WIDTH_P-1:0] data_q;
        logic                    pend_q;

        assign addr       = bus.i_rd_addr[slice_lo(p, ADDR_WIDTH_P) +: ADDR_WIDTH_P];
        assign valid_addr = addr_in_range(addr) && !addr_is_zero_reg(addr);
        // wr_legal already excludes the zero register and out-of-range writes,
        // so a hit can only occur on a real entry.
        assign wr_hit     = wr_legal && (bus.i_wr_addr == addr);

        // Same-cycle reservations are deliberately not looked at: an
        // instruction reading its own destination sees the old value as valid.
        always_comb begin
            data_d = '0;
            pend_d = 1'b0;
            if (valid_addr) begin
                if (wr_hit) begin
                    data_d = bus.i_wr_data;
                end else begin
                    data_d = mem[addr];
                    pend_d = pending[addr];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                data_q <= '0;
                pend_q <= 1'b0;
            end else if (bus.i_rd_en[p]) begin
                data_q <= data_d;
                pend_q <= pend_d;
            end
        end

        assign bus.o_rd_data[slice_lo(p, DATA_WIDTH_P) +: DATA_WIDTH_P] = data_q;
        assign bus.o_rd_pending[p]                                       = pend_q;
    end

endmodule
